// File: rtl/fixed_pred_pkg.sv
// rtl/fixed_pred_pkg.sv - shared types, coefficient table and helpers for the fixed predictor
//
// Purpose: common definitions for fixed_residual_calc and fixed_pred_history.
//   MAX_ORDER   highest fixed predictor order
//   order_t     3-bit predictor order
//   blk_state_t block segmentation FSM state
//   COEF        fixed-predictor coefficients, row = order, column = tap (x, x1..x4)
//   clamp_order maps orders 5-7 onto 4
//   coef_term   constant coefficient times a tap, built from shifts and adds
//   saturate    clamps a 32-bit signed value into a w-bit signed range
package fixed_pred_pkg;

   localparam int MAX_ORDER = 4;

   typedef logic [2:0] order_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } blk_state_t;

   localparam int COEF [0:MAX_ORDER][0:MAX_ORDER] = '{
      '{1,  0, 0,  0, 0},
      '{1, -1, 0,  0, 0},
      '{1, -2, 1,  0, 0},
      '{1, -3, 3, -1, 0},
      '{1, -4, 6, -4, 1}
   };

   function automatic order_t clamp_order(input order_t o);
      order_t r;
      r = (o > order_t'(MAX_ORDER)) ? order_t'(MAX_ORDER) : o;
      return r;
   endfunction

   // Only the coefficient values present in COEF are decoded.
   function automatic logic signed [31:0] coef_term(input logic signed [31:0] h, input int c);
      logic signed [31:0] r;
      case (c)
         1:       r = h;
         -1:      r = -h;
         2:       r = h <<< 1;
         -2:      r = -(h <<< 1);
         3:       r = (h <<< 1) + h;
         -3:      r = -((h <<< 1) + h);
         4:       r = h <<< 2;
         -4:      r = -(h <<< 2);
         6:       r = (h <<< 2) + (h <<< 1);
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                   input int unsigned w,
                                                   output logic ovf);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      logic signed [31:0] r;
      hi  = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
      lo  = -hi - 32'sd1;
      ovf = 1'b0;
      r   = v;
      if (v > hi) begin
         r   = hi;
         ovf = 1'b1;
      end else if (v < lo) begin
         r   = lo;
         ovf = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fixed_pred_history.sv
// rtl/fixed_pred_history.sv - sample history shift register with shift enable and sync clear
//
// Purpose: holds the previous MAX_ORDER samples of the current block.
// Ports:
//   iClock   clock
//   iReset   asynchronous reset, active low
//   iShift   push iSample in as the newest entry
//   iClear   synchronous clear, wins over iShift
//   iSample  sample to push
//   oHist    history, oHist[0] = x1 (newest) .. oHist[DEPTH-1] = x4 (oldest)
module fixed_pred_history
   import fixed_pred_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = MAX_ORDER
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic                       iShift,
   input  logic                       iClear,
   input  logic [W-1:0]               iSample,
   output logic [DEPTH-1:0][W-1:0]    oHist
);

   logic [DEPTH-1:0][W-1:0] hist_q;
   logic [DEPTH-1:0][W-1:0] hist_d;

   always_comb begin
      hist_d = hist_q;
      if (iClear) begin
         hist_d = '0;
      end else if (iShift) begin
         hist_d = {hist_q[DEPTH-2:0], iSample};
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         hist_q <= '0;
      end else begin
         hist_q <= hist_d;
      end
   end

   assign oHist = hist_q;

endmodule

// File: rtl/fixed_residual_calc.sv
// rtl/fixed_residual_calc.sv - FLAC fixed-polynomial residual generator with block segmentation
//
// Purpose: turns PCM samples into fixed-predictor residuals (orders 0-4), two-stage pipeline.
// Ports:
//   iClock, iReset      clock, asynchronous active-low reset
//   iEnable             global stall; low freezes everything and forces oValid low
//   iValid, iSample     input sample stream (accepted when iEnable & iValid)
//   iOrder              order for the next block (5-7 behave as 4)
//   oValid, oResidual   residual stream, verbatim sample during warm-up
//   oWarmup, oOverflow  verbatim warm-up marker, saturation marker
//   oBlockStart/End     first/last output of a block
//   oOrder              order in effect for the block of the current output
module fixed_residual_calc
   import fixed_pred_pkg::*;
#(
   parameter int SAMPLE_W   = 16,
   parameter int RES_W      = 16,
   parameter int BLOCK_SIZE = 4096
) (
   input  logic                       iClock,
   input  logic                       iReset,
   input  logic                       iEnable,
   input  logic                       iValid,
   input  logic signed [SAMPLE_W-1:0] iSample,
   input  logic [2:0]                 iOrder,
   output logic                       oValid,
   output logic signed [RES_W-1:0]    oResidual,
   output logic                       oWarmup,
   output logic                       oOverflow,
   output logic                       oBlockStart,
   output logic                       oBlockEnd,
   output logic [2:0]                 oOrder
);

   localparam int                CNT_W    = 16;
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(BLOCK_SIZE - 1);

   logic accept;
   assign accept = iEnable & iValid;

   // Block FSM: in IDLE the incoming sample is index 0 of a new block and takes iOrder.
   blk_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, idx;
   order_t           order_q, order_d, blk_order;
   logic             last;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      order_d   = order_q;
      idx       = (state_q == ST_IDLE) ? '0 : cnt_q;
      blk_order = (state_q == ST_IDLE) ? clamp_order(iOrder) : order_q;
      last      = (idx == LAST_IDX);
      if (accept) begin
         order_d = blk_order;
         if (last) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end else begin
            state_d = ST_RUN;
            cnt_d   = idx + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         order_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         order_q <= order_d;
      end
   end

   // History is cleared on the last sample so the next block starts from zeros.
   logic [MAX_ORDER-1:0][SAMPLE_W-1:0] hist;

   fixed_pred_history #(
      .W     (SAMPLE_W),
      .DEPTH (MAX_ORDER)
   ) u_hist (
      .iClock  (iClock),
      .iReset  (iReset),
      .iShift  (accept),
      .iClear  (accept & last),
      .iSample (iSample),
      .oHist   (hist)
   );

   // Stage 1: sample plus a snapshot of the history as it stood before this sample.
   logic                               s1_valid_q;
   logic signed [SAMPLE_W-1:0]         s1_x_q;
   logic [MAX_ORDER-1:0][SAMPLE_W-1:0] s1_h_q;
   order_t                             s1_order_q;
   logic                               s1_warm_q, s1_start_q, s1_end_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         s1_valid_q <= 1'b0;
         s1_x_q     <= '0;
         s1_h_q     <= '0;
         s1_order_q <= '0;
         s1_warm_q  <= 1'b0;
         s1_start_q <= 1'b0;
         s1_end_q   <= 1'b0;
      end else if (iEnable) begin
         s1_valid_q <= iValid;
         if (iValid) begin
            s1_x_q     <= iSample;
            s1_h_q     <= hist;
            s1_order_q <= blk_order;
            s1_warm_q  <= (idx < CNT_W'(blk_order));
            s1_start_q <= (idx == '0);
            s1_end_q   <= last;
         end
      end
   end

   // Weighted tap sum. Magnitude stays within SAMPLE_W+4 bits; 32-bit arithmetic
   // gives the same result and feeds the shared saturate helper directly.
   logic signed [31:0] taps [0:MAX_ORDER];
   logic signed [31:0] acc32;
   logic signed [31:0] sat_v;
   logic               sat_ovf;

   always_comb begin
      taps[0] = 32'(s1_x_q);
      for (int k = 1; k <= MAX_ORDER; k++) begin
         taps[k] = 32'($signed(s1_h_q[k-1]));
      end
      acc32 = '0;
      if (s1_warm_q) begin
         acc32 = taps[0];
      end else begin
         for (int k = 0; k <= MAX_ORDER; k++) begin
            acc32 = acc32 + coef_term(taps[k], COEF[s1_order_q][k]);
         end
      end
      sat_v = saturate(acc32, RES_W, sat_ovf);
   end

   // Stage 2: output registers; held while stalled or idle, qualified by oValid.
   logic                    s2_valid_q;
   logic signed [RES_W-1:0] s2_res_q;
   logic                    s2_warm_q, s2_ovf_q, s2_start_q, s2_end_q;
   order_t                  s2_order_q;

   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         s2_valid_q <= 1'b0;
         s2_res_q   <= '0;
         s2_warm_q  <= 1'b0;
         s2_ovf_q   <= 1'b0;
         s2_start_q <= 1'b0;
         s2_end_q   <= 1'b0;
         s2_order_q <= '0;
      end else if (iEnable) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_res_q   <= RES_W'(sat_v);
            s2_warm_q  <= s1_warm_q;
            s2_ovf_q   <= sat_ovf;
            s2_start_q <= s1_start_q;
            s2_end_q   <= s1_end_q;
            s2_order_q <= s1_order_q;
         end
      end
   end

   assign oValid      = s2_valid_q & iEnable;
   assign oResidual   = s2_res_q;
   assign oWarmup     = s2_warm_q;
   assign oOverflow   = s2_ovf_q;
   assign oBlockStart = s2_start_q;
   assign oBlockEnd   = s2_end_q;
   assign oOrder      = s2_order_q;

endmodule

// File: tb/tb_fixed_residual_calc.sv
// tb/tb_fixed_residual_calc.sv - self-checking bench for fixed_residual_calc
module tb_fixed_residual_calc;

   localparam int BS = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               vld;
   logic signed [15:0] smp;
   logic [2:0]         ord;
   logic               ov;
   logic signed [15:0] res;
   logic               warm, ovf, bst, bnd;
   logic [2:0]         oord;

   always #5 clk = ~clk;

   fixed_residual_calc #(
      .SAMPLE_W   (16),
      .RES_W      (16),
      .BLOCK_SIZE (BS)
   ) dut (
      .iClock      (clk),
      .iReset      (rst_n),
      .iEnable     (en),
      .iValid      (vld),
      .iSample     (smp),
      .iOrder      (ord),
      .oValid      (ov),
      .oResidual   (res),
      .oWarmup     (warm),
      .oOverflow   (ovf),
      .oBlockStart (bst),
      .oBlockEnd   (bnd),
      .oOrder      (oord)
   );

   typedef struct {
      int res;
      bit warm;
      bit ovf;
      bit bst;
      bit bnd;
      int ord;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   bit   chk_lat = 1'b0;

   // Reference model state: the samples of the current block, and its order.
   bit   in_blk = 1'b0;
   int   m_ord  = 0;
   int   blk[$];

   function automatic int binom(input int n, input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model(input int x, input int o, output exp_t ex);
      int n, v;
      if (!in_blk) begin
         in_blk = 1'b1;
         m_ord  = (o > 4) ? 4 : o;
         blk.delete();
      end
      n = blk.size();
      blk.push_back(x);
      ex.warm = (n < m_ord);
      if (ex.warm) v = x;
      else begin
         v = 0;
         for (int k = 0; k <= m_ord; k++)
            v += ((k % 2) ? -1 : 1) * binom(m_ord, k) * blk[n - k];
      end
      ex.ovf = 1'b0;
      if (v > 32767)  begin v = 32767;  ex.ovf = 1'b1; end
      if (v < -32768) begin v = -32768; ex.ovf = 1'b1; end
      ex.res = v;
      ex.bst = (n == 0);
      ex.bnd = (n == BS - 1);
      ex.ord = m_ord;
      ex.cyc = 0;
      if (ex.bnd) in_blk = 1'b0;
   endtask

   task automatic check_out();
      exp_t ex;
      if (!en) chk("stall_valid", ov, 0);
      if (chk_lat) chk("latency", ov, int'(q.size() > 0 && q[0].cyc + 1 == cyc));
      if (ov) begin
         if (q.size() == 0) chk("unexpected_out", ov, 0);
         else begin
            ex = q.pop_front();
            chk("residual", res,  ex.res);
            chk("warmup",   warm, ex.warm);
            chk("overflow", ovf,  ex.ovf);
            chk("blk_start", bst, ex.bst);
            chk("blk_end",  bnd,  ex.bnd);
            chk("order",    oord, ex.ord);
         end
      end
   endtask

   task automatic step(input bit v, input int x, input int o, input bit e);
      exp_t ex;
      vld = v;
      smp = 16'(x);
      ord = 3'(o);
      en  = e;
      @(posedge clk);
      cyc++;
      if (v && e) begin
         model(x, o, ex);
         ex.cyc = cyc;
         q.push_back(ex);
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1);
   endtask

   task automatic do_reset();
      vld   = 1'b0;
      en    = 1'b1;
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      blk.delete();
      in_blk = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, ov, 0);
      chk({tag, "_res"},   res, 0);
      chk({tag, "_warm"},  warm, 0);
      chk({tag, "_ovf"},   ovf, 0);
      chk({tag, "_start"}, bst, 0);
      chk({tag, "_end"},   bnd, 0);
      chk({tag, "_order"}, oord, 0);
   endtask

   function automatic int rnd16();
      logic signed [15:0] t;
      t = 16'($urandom);
      return int'(t);
   endfunction

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      vld   = 1'b0;
      smp   = '0;
      ord   = '0;
      #2;
      chk_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;

      // Order 2 ramp across a block boundary.
      for (int i = 0; i < 10; i++) step(1'b1, i, 2, 1'b1);
      idle(3);
      do_reset();

      // Order 1 constant with exact two-cycle latency.
      chk_lat = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b1, 100, 1, 1'b1);
      idle(3);
      chk_lat = 1'b0;
      do_reset();

      // Order 4 full-scale alternating input saturates.
      for (int i = 0; i < 12; i++) step(1'b1, (i % 2) ? -32768 : 32767, 4, 1'b1);
      idle(3);
      do_reset();

      // Order 3 random data with a 3-cycle stall.
      for (int i = 0; i < 20; i++) step(1'b1, rnd16(), 3, !(i >= 6 && i <= 8));
      idle(3);
      do_reset();

      // Order request changes mid-block; takes effect on the next block.
      for (int i = 0; i < 16; i++) step(1'b1, int'($urandom_range(0, 400)) - 200, (i < 3) ? 1 : 4, 1'b1);
      idle(3);
      do_reset();

      // Asynchronous reset mid-block.
      for (int i = 0; i < 5; i++) step(1'b1, rnd16(), 2, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("midreset");
      q.delete();
      blk.delete();
      in_blk = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step(1'b1, int'($urandom_range(0, 2000)) - 1000, 3, 1'b1);
      idle(3);

      // Random mix of orders, valid gaps and stalls across many blocks.
      for (int i = 0; i < 120; i++)
         step($urandom_range(0, 3) != 0, rnd16(), int'($urandom_range(0, 7)), $urandom_range(0, 7) != 0);
      idle(4);
      chk("drained", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fixed_residual_calc.md
Name: fixed_residual_calc

Overview:
Upstream neighbour of the residual encoding stage. Turns the raw PCM sample stream into FLAC fixed-polynomial residuals (orders 0-4). Its output pair oValid/oResidual drives the encoder's iValid/iResidual inputs directly. It also segments the stream into blocks and flags the warm-up samples that must be written verbatim.

Parameters:
SAMPLE_W, 16, signed input sample width
RES_W, 16, signed output residual width; results outside this range saturate
BLOCK_SIZE, 4096, samples per block; supported range 8..65535
MAX_ORDER, 4, highest fixed predictor order (fixed value, not tunable)

Ports:
iClock  in  1  clock
iReset  in  1  asynchronous reset, active low
iEnable  in  1  global stall; when low, all state holds and oValid=0
iValid  in  1  iSample valid this cycle
iSample  in  SAMPLE_W  signed PCM sample
iOrder  in  3  predictor order for the next block; values 5-7 are treated as 4
oValid  out  1  oResidual valid
oResidual  out  RES_W  signed residual, or the verbatim sample during warm-up
oWarmup  out  1  current output is a verbatim warm-up sample
oOverflow  out  1  current residual was saturated
oBlockStart  out  1  first output of a block
oBlockEnd  out  1  last output of a block
oOrder  out  3  order in effect for the current block (clamped to 0-4)

Behaviour:
- Reset (iReset=0, asynchronous): all outputs 0; history registers 0; sample counter 0; pipeline valids cleared; state IDLE. Takes effect immediately, including mid-block. The next accepted sample starts a new block.
- Accept condition: iEnable & iValid. No backpressure; one sample per cycle maximum.
- Latency: fixed 2 cycles from accept to oValid when iEnable is held high.
  - Stage 1 registers the sample, history x1..x4, order, counter flags.
  - Stage 2 registers the sum, saturation and flags.
- iEnable=0 freezes both pipeline stages and the counter. oValid is forced 0 and the other outputs hold. Resuming iEnable continues with no sample loss or duplication.
- Block FSM: IDLE -> RUN on the first accept.
  - The first accept latches clamp(iOrder) into the block order, sets counter=0 and raises oBlockStart on that sample's output.
  - The counter increments on every accept.
  - At counter==BLOCK_SIZE-1 the sample's output carries oBlockEnd, history is cleared and the FSM returns to IDLE. The next sample starts a new block with a fresh iOrder.
  - iOrder changes mid-block are ignored.
- Warm-up: samples with counter < order output the verbatim sample, sign-extended or saturated to RES_W, with oWarmup=1. Order 0 has no warm-up.
- Residual, computed at SAMPLE_W+4 bits signed:
  - order 0: x
  - order 1: x - x1
  - order 2: x - 2*x1 + x2
  - order 3: x - 3*x1 + 3*x2 - x3
  - order 4: x - 4*x1 + 6*x2 - 4*x3 + x4
  - Multiplications use shift-add only.
- Saturation: a result above 2^(RES_W-1)-1 or below -2^(RES_W-1) clamps to that bound and sets oOverflow=1 for that sample. oOverflow is 0 otherwise and for warm-up samples that fit.
- History shifts on every accept: x4<=x3, x3<=x2, x2<=x1, x1<=x. It is cleared at block end.
- Simultaneous events: block end and the next block's first sample may arrive on consecutive cycles with no bubble. oBlockStart and oBlockEnd are only both set when BLOCK_SIZE==1, which is unsupported.

Decomposition:
- Package fixed_pred_pkg:
  - MAX_ORDER=4
  - an order_t typedef (3 bits)
  - the coefficient table as constants (1; 1,-1; 1,-2,1; 1,-3,3,-1; 1,-4,6,-4,1)
  - a saturate function.
- One natural sub-module, fixed_pred_history: the 4-deep sample shift register with enable and synchronous clear. The sum and saturate logic stays in the top module.

Test Plan:
- Order 2 with ramp 0,1,2,...,9 (BLOCK_SIZE=8) -> outputs 0,1 with oWarmup=1, then six 0s. oBlockStart on the first output, oBlockEnd on the 8th. Sample 8 restarts with oBlockStart and is verbatim 8.
- Order 1 with constant 100 -> first output 100 with oWarmup=1, then all 0s. oOverflow is never set. Latency is exactly 2 cycles.
- Order 4 with alternating 32767,-32768 -> after 4 warm-up samples the raw residual is ±524280. Outputs clamp to 32767/-32768 with oOverflow=1.
- iEnable dropped for 3 cycles mid-stream (order 3, random data) -> oValid=0 during the gap. The resumed residuals match the golden model with no missing or duplicate samples.
- iOrder changed from 1 to 4 at sample 3 of a block -> oOrder stays 1 until the next block, then reads 4 with 4 warm-up samples.
- iReset pulsed low mid-block at sample 5 -> outputs go to 0 immediately. The next sample produces oBlockStart with the warm-up count for the current iOrder.
